// File: rtl/weight_fifo_drain.sv
// Weight FIFO read-side controller: pops rows and skews column c by c cycles.
// Busy spans the drain; done marks the last skewed word.
module weight_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_rows,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] fifo_data,
  output logic                             fifo_en,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_out,
  output logic [ARRAY_SIZE-1:0]            weight_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int FW = $clog2(ARRAY_SIZE);
  localparam logic [FW-1:0] FL_LAST = FW'(ARRAY_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]           st_q, st_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [FW-1:0]        fl_q, fl_d;
  logic                 zd_q, zd_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    fl_d  = fl_q;
    zd_d  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            st_d  = READ;
            cnt_d = num_rows;
          end else begin
            zd_d = 1'b1;
          end
        end
      end
      READ: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          st_d = FLUSH;
          fl_d = '0;
        end
      end
      FLUSH: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == FL_LAST) begin
          st_d = IDLE;
          fl_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      fl_q  <= '0;
      zd_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      fl_q  <= fl_d;
      zd_q  <= zd_d;
    end
  end

  assign fifo_en = (st_q == READ);
  assign busy    = (st_q != IDLE);
  assign done    = zd_q | ((st_q == FLUSH) && (fl_q == FL_LAST));

  // Column c owns a c+1 deep delay line; invalid slots carry zero.
  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
    logic [DATA_WIDTH-1:0] d_q [c+1];
    logic [c:0]            v_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
        for (int k = 0; k <= c; k++) d_q[k] <= '0;
      end else begin
        v_q[0] <= fifo_en;
        d_q[0] <= fifo_en ? fifo_data[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= c; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= v_q[k-1] ? d_q[k-1] : '0;
        end
      end
    end

    assign weight_out[c*DATA_WIDTH +: DATA_WIDTH] = d_q[c];
    assign weight_valid[c] = v_q[c];
  end

endmodule

// File: tb/tb_weight_fifo_drain.sv
// Bench for weight_fifo_drain: window-based reference model plus
// hand-computed checkpoints over directed drains.
module tb_weight_fifo_drain;
  localparam int DW = 8;
  localparam int A  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_rows;
  logic [A*DW-1:0] fifo_data;
  logic          fifo_en;
  logic [A*DW-1:0] weight_out;
  logic [A-1:0]  weight_valid;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  weight_fifo_drain #(
    .DATA_WIDTH(DW),
    .ARRAY_SIZE(A),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_rows    (num_rows),
    .fifo_data   (fifo_data),
    .fifo_en     (fifo_en),
    .weight_out  (weight_out),
    .weight_valid(weight_valid),
    .busy        (busy),
    .done        (done)
  );

  // model: time windows of the accepted drain plus a log of popped rows
  int  cyc      = 0;
  bit  known    = 0;
  bit  active   = 0;
  int  rd_lo    = 0;
  int  rd_hi    = 0;
  int  busy_hi  = 0;
  int  zdone_at = -10;
  logic [A*DW-1:0] rows [int];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [A*DW-1:0] ew;
    logic [A*DW-1:0] r;
    logic [A-1:0]    ev;
    bit e_busy, e_en, e_done;
    if (known) begin
      e_busy = active && cyc >= rd_lo && cyc <= busy_hi;
      e_en   = active && cyc >= rd_lo && cyc <= rd_hi;
      e_done = (active && cyc == busy_hi) || (cyc == zdone_at);
      ew = '0;
      ev = '0;
      for (int c = 0; c < A; c++) begin
        if (rows.exists(cyc - 1 - c)) begin
          r = rows[cyc - 1 - c];
          ew[c*DW +: DW] = r[c*DW +: DW];
          ev[c] = 1'b1;
        end
      end
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_fifo_en", 32'(fifo_en), 32'(e_en));
      chk("m_done", 32'(done), 32'(e_done));
      chk("m_valid", 32'(weight_valid), 32'(ev));
      chk("m_weight", weight_out, ew);
    end
    if (reset) begin
      known    = 1;
      active   = 0;
      zdone_at = -10;
      rows.delete();
    end else if (known) begin
      if (active && cyc >= rd_lo && cyc <= rd_hi) rows[cyc] = fifo_data;
      if (start && !(active && cyc <= busy_hi)) begin
        if (num_rows == '0) begin
          zdone_at = cyc + 1;
        end else begin
          active  = 1;
          rd_lo   = cyc + 1;
          rd_hi   = cyc + int'(num_rows);
          busy_hi = rd_hi + A;
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    fifo_data = '0;

    // 1: reset with random stimulus
    for (int i = 0; i < 2; i++) begin
      start     = 1'($urandom);
      num_rows  = CW'($urandom);
      fifo_data = $urandom;
      step();
    end
    chk("t1_en", 32'(fifo_en), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_valid", 32'(weight_valid), 0);
    chk("t1_weight", weight_out, 0);
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("t1_en_after", 32'(fifo_en), 0);

    // 2: single row
    fifo_data = 32'h04030201;
    num_rows  = 4'd1;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("t2_en", 32'(fifo_en), 1);
    step();
    fifo_data = 32'hdeadbeef;
    chk("t2_w0", weight_out, 32'h00000001);
    chk("t2_v0", 32'(weight_valid), 32'h1);
    step();
    chk("t2_w1", weight_out, 32'h00000200);
    chk("t2_en_off", 32'(fifo_en), 0);
    step();
    chk("t2_w2", weight_out, 32'h00030000);
    step();
    chk("t2_w3", weight_out, 32'h04000000);
    chk("t2_v3", 32'(weight_valid), 32'h8);
    chk("t2_done", 32'(done), 1);
    chk("t2_busy", 32'(busy), 1);
    step();
    chk("t2_idle", 32'(busy), 0);

    // 3: three extreme rows
    fifo_data = 32'h80808080;
    num_rows  = 4'd3;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    fifo_data = 32'h7f7f7f7f;
    chk("t3_c0_r0", 32'(weight_out[7:0]), 32'h80);
    step();
    fifo_data = 32'h55555555;
    chk("t3_c0_r1", 32'(weight_out[7:0]), 32'h7f);
    step();
    fifo_data = $urandom;
    chk("t3_c0_r2", 32'(weight_out[7:0]), 32'h55);
    chk("t3_en_off", 32'(fifo_en), 0);
    step();
    chk("t3_c3_r0", 32'(weight_out[31:24]), 32'h80);
    step();
    step();
    chk("t3_c3_r2", 32'(weight_out[31:24]), 32'h55);
    chk("t3_done", 32'(done), 1);
    step();

    // 4: zero rows
    num_rows = 4'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_en", 32'(fifo_en), 0);
    step();
    chk("t4_done_off", 32'(done), 0);

    // 5: start ignored while busy, accepted after done
    fifo_data = $urandom;
    num_rows  = 4'd2;
    start     = 1'b1;
    step();
    num_rows = 4'd7;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_no_en", 32'(fifo_en), 0);
    step();
    chk("t5_done", 32'(done), 1);
    start    = 1'b1;
    num_rows = 4'd1;
    fifo_data = 32'h11223344;
    step();
    chk("t5_idle", 32'(busy), 0);
    step();
    start = 1'b0;
    chk("t5_restart", 32'(fifo_en), 1);
    for (int i = 0; i < 4; i++) step();
    chk("t5_done2", 32'(done), 1);
    chk("t5_w3", 32'(weight_out[31:24]), 32'h11);
    step();

    // 6: reset mid-drain, then a clean drain
    fifo_data = $urandom;
    num_rows  = 4'd5;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_en", 32'(fifo_en), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(weight_valid), 0);
    chk("t6_weight", weight_out, 0);
    chk("t6_done", 32'(done), 0);
    num_rows = 4'd2;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("t6_en1", 32'(fifo_en), 1);
    step();
    chk("t6_en2", 32'(fifo_en), 1);
    step();
    chk("t6_en3", 32'(fifo_en), 0);
    step();
    step();
    step();
    chk("t6_done_s6", 32'(done), 1);
    for (int i = 0; i < 3; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
